sysid_plant: RTL and testbench

SYSID_PLANT -- requirements
Module: sysid_plant

---
 rtl/sysid_plant_pkg.sv | 35 +++
 rtl/sysid_plant_if.sv | 26 ++
 rtl/sysid_lfsr16.sv | 21 ++
 rtl/sysid_plant.sv | 152 +++++++++++++++
 tb/tb_sysid_plant.sv | 224 ++++++++++++++++++++++
 5 files changed

// File: rtl/sysid_plant_pkg.sv
// Shared types, constants and the saturation helper for the sysid_plant plant model.
package sysid_plant_pkg;

  typedef enum logic [1:0] {StIdle, StLoad, StRun} state_e;

  localparam logic [15:0] LfsrSeed = 16'hACE1;
  // Feedback mask for x^16 + x^14 + x^13 + x^11 + 1 (bits 15, 13, 12, 10).
  localparam logic [15:0] LfsrTaps = 16'hB400;

  localparam int unsigned SatW = 128;

  typedef struct packed {
    logic            ovr;
    logic [SatW-1:0] val;
  } sat_t;

  // Clamp a wide signed value into a w-bit signed range.
  function automatic sat_t sat_fn(input logic signed [SatW-1:0] v, input int unsigned w);
    logic signed [SatW-1:0] hi;
    logic signed [SatW-1:0] lo;
    sat_t r;
    hi = $signed({1'b0, {(SatW-1){1'b1}}}) >>> (SatW - w);
    lo = ~hi;
    r.ovr = (v > hi) || (v < lo);
    if (v > hi) begin
      r.val = hi;
    end else if (v < lo) begin
      r.val = lo;
    end else begin
      r.val = v;
    end
    return r;
  endfunction

endpackage

// File: rtl/sysid_plant_if.sv
// Coefficient-load and sample-stream signals of sysid_plant.
interface sysid_plant_if #(
  parameter int unsigned WIDTH = 32
);
  logic             i_cfg_valid;
  logic             o_cfg_ready;
  logic [WIDTH-1:0] i_cfg_data;
  logic             i_cfg_last;
  logic             o_cfg_err;
  logic             i_din_valid;
  logic [WIDTH-1:0] i_din;
  logic             o_valid;
  logic [WIDTH-1:0] o_din_d;
  logic [WIDTH-1:0] o_desired;
  logic             o_ovr;

  modport master (
    output i_cfg_valid, i_cfg_data, i_cfg_last, i_din_valid, i_din,
    input  o_cfg_ready, o_cfg_err, o_valid, o_din_d, o_desired, o_ovr
  );

  modport slave (
    input  i_cfg_valid, i_cfg_data, i_cfg_last, i_din_valid, i_din,
    output o_cfg_ready, o_cfg_err, o_valid, o_din_d, o_desired, o_ovr
  );
endinterface

// File: rtl/sysid_lfsr16.sv
// 16-bit Fibonacci LFSR noise source, advanced once per enabled cycle.
module sysid_lfsr16
  import sysid_plant_pkg::*;
(
  input  logic        clk,
  input  logic        rstn,
  input  logic        en,
  output logic [15:0] q
);
  logic [15:0] lfsr_q;

  always_ff @(posedge clk) begin
    if (!rstn) begin
      lfsr_q <= LfsrSeed;
    end else if (en) begin
      lfsr_q <= {lfsr_q[14:0], ^(lfsr_q & LfsrTaps)};
    end
  end

  assign q = lfsr_q;
endmodule

// File: rtl/sysid_plant.sv
// FIR plant model with double-buffered coefficients and a 2-stage saturating datapath.
// Define SYSID_PLANT_NOISE_EN to add i_noise_shift and LFSR noise before saturation.
module sysid_plant
  import sysid_plant_pkg::*;
#(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned FRAC  = 20,
  parameter int unsigned TAPS  = 2
) (
  input logic          clk,
  input logic          rstn,
`ifdef SYSID_PLANT_NOISE_EN
  input logic [4:0]    i_noise_shift,
`endif
  sysid_plant_if.slave bus
);
  localparam int unsigned IdxW  = $clog2(TAPS);
  localparam int unsigned ProdW = 2 * WIDTH;
  localparam int unsigned SumW  = ProdW + $clog2(TAPS);
  localparam logic [IdxW-1:0] LastIdx = IdxW'(TAPS - 1);

  state_e                  state_q;
  logic                    loaded_q;
  logic [IdxW-1:0]         idx_q;
  logic signed [WIDTH-1:0] shadow_q [TAPS];
  logic signed [WIDTH-1:0] active_q [TAPS];
  logic                    cfg_err_q;
  logic                    cfg_acc;
  logic [IdxW-1:0]         pos;

  assign bus.o_cfg_ready = rstn;
  assign cfg_acc         = bus.i_cfg_valid & rstn;
  // A word arriving outside LOAD always starts a fresh load at tap 0.
  assign pos             = (state_q == StLoad) ? idx_q : '0;

  always_ff @(posedge clk) begin
    if (!rstn) begin
      state_q   <= StIdle;
      loaded_q  <= 1'b0;
      idx_q     <= '0;
      cfg_err_q <= 1'b0;
      for (int k = 0; k < TAPS; k++) begin
        shadow_q[k] <= '0;
        active_q[k] <= '0;
      end
    end else begin
      cfg_err_q <= 1'b0;
      if (cfg_acc) begin
        if (bus.i_cfg_last && (pos == LastIdx)) begin
          for (int k = 0; k < TAPS - 1; k++) active_q[k] <= shadow_q[k];
          active_q[TAPS-1] <= bus.i_cfg_data;
          loaded_q <= 1'b1;
          idx_q    <= '0;
          state_q  <= StRun;
        end else if (bus.i_cfg_last || (pos == LastIdx)) begin
          cfg_err_q <= 1'b1;
          idx_q     <= '0;
          state_q   <= loaded_q ? StRun : StIdle;
        end else begin
          shadow_q[pos] <= bus.i_cfg_data;
          idx_q         <= pos + 1'b1;
          state_q       <= StLoad;
        end
      end
    end
  end

  // Stage 1: tap delay line and registered full-width products.
  logic signed [WIDTH-1:0] dly_q    [TAPS-1];
  logic signed [WIDTH-1:0] tap_in   [TAPS];
  logic signed [ProdW-1:0] prod_q   [TAPS];
  logic                    s1_valid_q;
  logic [WIDTH-1:0]        s1_din_q;

  always_comb begin
    tap_in[0] = bus.i_din;
    for (int k = 1; k < TAPS; k++) tap_in[k] = dly_q[k-1];
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      s1_valid_q <= 1'b0;
      s1_din_q   <= '0;
      for (int k = 0; k < TAPS; k++) prod_q[k] <= '0;
      for (int k = 0; k < TAPS - 1; k++) dly_q[k] <= '0;
    end else begin
      s1_valid_q <= bus.i_din_valid;
      if (bus.i_din_valid) begin
        s1_din_q <= bus.i_din;
        for (int k = 0; k < TAPS; k++) prod_q[k] <= ProdW'(active_q[k]) * ProdW'(tap_in[k]);
        dly_q[0] <= bus.i_din;
        for (int k = 1; k < TAPS - 1; k++) dly_q[k] <= dly_q[k-1];
      end
    end
  end

  // Stage 2: sum, truncating shift, optional noise, saturate.
  logic signed [SumW-1:0] sum;
  logic signed [SatW-1:0] acc;
  sat_t                   sat;
  logic                   unused_sat;

`ifdef SYSID_PLANT_NOISE_EN
  logic [15:0] noise;

  sysid_lfsr16 u_lfsr (
    .clk  (clk),
    .rstn (rstn),
    .en   (bus.i_din_valid),
    .q    (noise)
  );
`endif

  always_comb begin
    sum = '0;
    for (int k = 0; k < TAPS; k++) sum = sum + SumW'(prod_q[k]);
    acc = SatW'(sum >>> FRAC);
`ifdef SYSID_PLANT_NOISE_EN
    acc = acc + (SatW'($signed(noise)) <<< i_noise_shift);
`endif
    sat = sat_fn(acc, WIDTH);
  end

  assign unused_sat = ^sat.val[SatW-1:WIDTH];

  logic             valid_q;
  logic [WIDTH-1:0] din_d_q;
  logic [WIDTH-1:0] desired_q;
  logic             ovr_q;

  always_ff @(posedge clk) begin
    if (!rstn) begin
      valid_q   <= 1'b0;
      din_d_q   <= '0;
      desired_q <= '0;
      ovr_q     <= 1'b0;
    end else begin
      valid_q <= s1_valid_q;
      if (s1_valid_q) begin
        din_d_q   <= s1_din_q;
        desired_q <= sat.val[WIDTH-1:0];
        ovr_q     <= sat.ovr;
      end
    end
  end

  assign bus.o_cfg_err = cfg_err_q;
  assign bus.o_valid   = valid_q;
  assign bus.o_din_d   = din_d_q;
  assign bus.o_desired = desired_q;
  assign bus.o_ovr     = ovr_q;
endmodule

// File: tb/tb_sysid_plant.sv
// Randomized and directed bench for sysid_plant against an arithmetic FIR model.
module tb_sysid_plant;
  localparam int unsigned WIDTH = 32;
  localparam int unsigned FRAC  = 20;
  localparam int unsigned TAPS  = 2;
  localparam logic signed [127:0] MaxV = 128'sd2147483647;
  localparam logic signed [127:0] MinV = -128'sd2147483648;

  logic clk  = 1'b0;
  logic rstn = 1'b0;
  always #5 clk = ~clk;

  sysid_plant_if #(.WIDTH(WIDTH)) bus ();

  sysid_plant #(.WIDTH(WIDTH), .FRAC(FRAC), .TAPS(TAPS)) dut (
    .clk  (clk),
    .rstn (rstn),
    .bus  (bus)
  );

  typedef struct {
    int          due;
    logic [31:0] din;
    logic [31:0] q;
    bit          ovr;
  } exp_t;

  logic signed [31:0] m_act  [TAPS];
  logic signed [31:0] m_hist [TAPS];
  logic signed [31:0] m_shadow [$];
  exp_t               pend [$];
  logic [31:0]        hold_q;
  int                 cyc;
  int                 n_tests;
  int                 n_fail;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s at cycle %0d: got %0h expected %0h", tag, cyc, got, exp);
    end
  endtask

  task automatic model_clear();
    for (int k = 0; k < TAPS; k++) begin
      m_act[k]  = '0;
      m_hist[k] = '0;
    end
    m_shadow.delete();
    pend.delete();
    hold_q = '0;
  endtask

  // y[n] = sum_k a[k]*x[n-k], then >> FRAC and clamp to 32-bit signed.
  task automatic model_sample(input logic [31:0] x);
    logic signed [127:0] acc;
    exp_t e;
    for (int k = TAPS - 1; k > 0; k--) m_hist[k] = m_hist[k-1];
    m_hist[0] = $signed(x);
    acc = '0;
    for (int k = 0; k < TAPS; k++) acc += 128'(m_act[k]) * 128'(m_hist[k]);
    acc = acc >>> FRAC;
    e.due = cyc + 1;
    e.din = x;
    e.ovr = (acc > MaxV) || (acc < MinV);
    if (acc > MaxV)      e.q = 32'h7FFF_FFFF;
    else if (acc < MinV) e.q = 32'h8000_0000;
    else                 e.q = acc[31:0];
    pend.push_back(e);
  endtask

  task automatic model_cfg(input logic [31:0] d, input bit last, output bit err);
    err = 1'b0;
    if (last && m_shadow.size() == TAPS - 1) begin
      for (int k = 0; k < TAPS - 1; k++) m_act[k] = m_shadow[k];
      m_act[TAPS-1] = $signed(d);
      m_shadow.delete();
    end else if (last || m_shadow.size() == TAPS - 1) begin
      err = 1'b1;
      m_shadow.delete();
    end else begin
      m_shadow.push_back($signed(d));
    end
  endtask

  task automatic step(input bit cv, input logic [31:0] cd, input bit cl,
                      input bit dv, input logic [31:0] dx);
    bit   exp_err;
    bit   exp_v;
    exp_t e;
    bus.i_cfg_valid = cv;
    bus.i_cfg_data  = cd;
    bus.i_cfg_last  = cl;
    bus.i_din_valid = dv;
    bus.i_din       = dx;
    @(posedge clk);
    cyc++;
    exp_err = 1'b0;
    // Sample is modelled before the cfg word so a same-edge commit uses the old bank.
    if (dv) model_sample(dx);
    if (cv) model_cfg(cd, cl, exp_err);
    #1;
    exp_v = (pend.size() > 0) && (pend[0].due == cyc);
    check("o_valid", bus.o_valid, exp_v);
    check("o_cfg_err", bus.o_cfg_err, exp_err);
    if (exp_v) begin
      e = pend.pop_front();
      check("o_desired", bus.o_desired, e.q);
      check("o_din_d", bus.o_din_d, e.din);
      check("o_ovr", bus.o_ovr, e.ovr);
      hold_q = e.q;
    end else begin
      check("o_desired_hold", bus.o_desired, hold_q);
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, '0, 1'b0, 1'b0, '0);
  endtask

  task automatic do_reset(input bit dv, input logic [31:0] dx);
    rstn            = 1'b0;
    bus.i_cfg_valid = 1'b0;
    bus.i_cfg_last  = 1'b0;
    bus.i_din_valid = dv;
    bus.i_din       = dx;
    @(posedge clk);
    cyc++;
    model_clear();
    #1;
    check("rst_o_valid", bus.o_valid, 1'b0);
    check("rst_o_desired", bus.o_desired, 32'h0);
    check("rst_o_din_d", bus.o_din_d, 32'h0);
    check("rst_o_ovr", bus.o_ovr, 1'b0);
    check("rst_o_cfg_err", bus.o_cfg_err, 1'b0);
    rstn            = 1'b1;
    bus.i_din_valid = 1'b0;
    #1;
    check("o_cfg_ready", bus.o_cfg_ready, 1'b1);
  endtask

  task automatic load2(input logic [31:0] c0, input logic [31:0] c1);
    step(1'b1, c0, 1'b0, 1'b0, '0);
    step(1'b1, c1, 1'b1, 1'b0, '0);
  endtask

  function automatic logic [31:0] rnd_val();
    logic [31:0] v;
    if ($urandom_range(0, 4) == 0) v = $urandom();
    else v = $urandom_range(0, 32'h0080_0000) - 32'h0040_0000;
    return v;
  endfunction

  initial begin
    n_tests = 0;
    n_fail  = 0;
    cyc     = 0;
    bus.i_cfg_valid = 1'b0;
    bus.i_cfg_data  = '0;
    bus.i_cfg_last  = 1'b0;
    bus.i_din_valid = 1'b0;
    bus.i_din       = '0;
    model_clear();
    do_reset(1'b0, '0);
    do_reset(1'b0, '0);

    // Unloaded plant outputs zero but passes the sample through.
    step(1'b0, '0, 1'b0, 1'b1, 32'h0010_0000);
    idle(2);

    do_reset(1'b0, '0);
    load2(32'h0010_0000, 32'h0008_0000);
    step(1'b0, '0, 1'b0, 1'b1, 32'h0010_0000);
    step(1'b0, '0, 1'b0, 1'b1, 32'h0020_0000);
    idle(2);

    // Saturation both ways.
    do_reset(1'b0, '0);
    load2(32'h4000_0000, 32'h0);
    step(1'b0, '0, 1'b0, 1'b1, 32'h4000_0000);
    idle(1);
    step(1'b0, '0, 1'b0, 1'b1, 32'hC000_0000);
    idle(2);

    // Malformed loads from IDLE and from RUN.
    do_reset(1'b0, '0);
    step(1'b1, 32'h0010_0000, 1'b1, 1'b0, '0);
    step(1'b0, '0, 1'b0, 1'b1, 32'h0030_0000);
    idle(2);
    load2(32'h0010_0000, 32'h0);
    step(1'b1, 32'h0050_0000, 1'b1, 1'b0, '0);
    step(1'b0, '0, 1'b0, 1'b1, 32'h0030_0000);
    step(1'b1, 32'h0050_0000, 1'b0, 1'b0, '0);
    step(1'b1, 32'h0050_0000, 1'b0, 1'b0, '0);
    step(1'b0, '0, 1'b0, 1'b1, 32'hFFF0_0000);
    idle(2);

    // Reload while streaming every cycle.
    for (int i = 0; i < 8; i++) begin
      step(i == 2 || i == 3, (i == 2) ? 32'h0020_0000 : 32'h0, i == 3, 1'b1,
           32'h0001_0000 * (i + 1));
    end
    idle(2);

    // Reset mid-load with a sample in flight.
    step(1'b1, 32'h0030_0000, 1'b0, 1'b1, 32'h0010_0000);
    do_reset(1'b1, 32'h0010_0000);
    idle(2);
    step(1'b0, '0, 1'b0, 1'b1, 32'h0010_0000);
    idle(2);

    // Randomized traffic.
    for (int i = 0; i < 500; i++) begin
      step($urandom_range(0, 3) == 0, rnd_val(), $urandom_range(0, 2) != 0,
           $urandom_range(0, 1) == 1, rnd_val());
    end
    idle(3);
    check("pend_drained", 64'(pend.size()), 64'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
